// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, IMEM handshake, hold buffer, delay-slot redirect
// Optional FETCH_TRACE_EN: prints every delivered instruction, squash and redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC,
    input  logic        Request_Alt_PC,
    input  logic        WANT_FREEZE,
    output logic        IMEM_Req,
    output logic [31:0] IMEM_Addr,
    input  logic        IMEM_Ack,
    input  logic [31:0] IMEM_Data,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Fetch_Valid_OUT
);

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        buf_valid;
    logic        squash;
    logic        squash_nxt;
    logic        redir_pend;
    logic        redir_pend_nxt;
    logic [31:0] redir_pc;
    logic [31:0] redir_pc_nxt;
    logic        req_q;

    logic        ack_acc;
    logic        take;
    logic        redir_rise;
    logic        slot_present;
    logic        discard;
    logic        deliver_new;
    logic [31:0] redir_target;
    logic        alt_pc_unused;

    assign alt_pc_unused      = ^Alt_PC[1:0];
    assign IMEM_Req           = !RESET && !buf_valid;
    assign IMEM_Addr          = {pc[31:2], 2'b00};
    assign ack_acc            = IMEM_Req && IMEM_Ack;
    assign take               = ack_acc && !squash;
    assign redir_rise         = Request_Alt_PC && !req_q;
    assign redir_target       = {Alt_PC[31:2], 2'b00};
    assign slot_present       = Fetch_Valid_OUT || buf_valid;
    assign deliver_new        = take && !discard;
    assign Instr_PC_Plus4_OUT = Instr_PC_OUT + 32'd4;

    always_comb begin
        pc_nxt         = pc;
        squash_nxt     = squash;
        redir_pend_nxt = redir_pend;
        redir_pc_nxt   = redir_pc;
        discard        = 1'b0;

        if (ack_acc && squash) begin
            pc_nxt     = redir_pc;
            squash_nxt = 1'b0;
        end

        if (take) begin
            if (redir_pend) begin
                pc_nxt         = redir_pc;
                redir_pend_nxt = 1'b0;
            end else begin
                pc_nxt = pc + 32'd4;
            end
        end

        // Delay slot not yet seen: a word arriving now is the slot itself
        if (redir_rise) begin
            if (!slot_present && take) begin
                pc_nxt = redir_target;
            end else if (!slot_present) begin
                redir_pend_nxt = 1'b1;
                redir_pc_nxt   = redir_target;
            end else if (!IMEM_Req || ack_acc) begin
                pc_nxt     = redir_target;
                discard    = ack_acc;
                squash_nxt = 1'b0;
            end else begin
                squash_nxt   = 1'b1;
                redir_pc_nxt = redir_target;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc              <= RESET_PC;
            buf_instr       <= 32'h0;
            buf_pc          <= 32'h0;
            buf_valid       <= 1'b0;
            squash          <= 1'b0;
            redir_pend      <= 1'b0;
            redir_pc        <= 32'h0;
            req_q           <= 1'b0;
            Instr1_OUT      <= 32'h0;
            Instr_PC_OUT    <= 32'h0;
            Fetch_Valid_OUT <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            squash     <= squash_nxt;
            redir_pend <= redir_pend_nxt;
            redir_pc   <= redir_pc_nxt;
            req_q      <= Request_Alt_PC;

            if (!WANT_FREEZE) begin
                if (buf_valid) begin
                    Instr1_OUT      <= buf_instr;
                    Instr_PC_OUT    <= buf_pc;
                    Fetch_Valid_OUT <= 1'b1;
                    buf_valid       <= 1'b0;
                end else if (deliver_new) begin
                    Instr1_OUT      <= IMEM_Data;
                    Instr_PC_OUT    <= IMEM_Addr;
                    Fetch_Valid_OUT <= 1'b1;
                end else begin
                    Instr1_OUT      <= 32'h0;
                    Fetch_Valid_OUT <= 1'b0;
                end
            end else if (deliver_new) begin
                buf_instr <= IMEM_Data;
                buf_pc    <= IMEM_Addr;
                buf_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (!WANT_FREEZE && buf_valid)
                $display("IF:PC=%x Instr=%x", buf_pc, buf_instr);
            else if (!WANT_FREEZE && deliver_new)
                $display("IF:PC=%x Instr=%x", IMEM_Addr, IMEM_Data);
            if (ack_acc && squash)
                $display("IF:squash PC=%x resume=%x", IMEM_Addr, redir_pc);
            if (redir_rise)
                $display("IF:redirect target=%x", redir_target);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a queue-based fetch model
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Alt_PC;
    logic        Request_Alt_PC;
    logic        WANT_FREEZE;
    logic        IMEM_Req;
    logic [31:0] IMEM_Addr;
    logic        IMEM_Ack;
    logic [31:0] IMEM_Data;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Fetch_Valid_OUT;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Alt_PC             (Alt_PC),
        .Request_Alt_PC     (Request_Alt_PC),
        .WANT_FREEZE        (WANT_FREEZE),
        .IMEM_Req           (IMEM_Req),
        .IMEM_Addr          (IMEM_Addr),
        .IMEM_Ack           (IMEM_Ack),
        .IMEM_Data          (IMEM_Data),
        .Instr1_OUT         (Instr1_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
        .Fetch_Valid_OUT    (Fetch_Valid_OUT)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;

    // Model: hold is the (at most one-deep) frozen-delivery queue, dlv logs every delivered PC
    word_t       hold[$];
    logic [31:0] dlv[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_rpc = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_ipc = 32'h0;
    logic        m_sq = 1'b0;
    logic        m_rpend = 1'b0;
    logic        m_reqq = 1'b0;
    logic        m_fv = 1'b0;

    int checks = 0;
    int failures = 0;
    int lat = 0;
    int wcnt = 0;
    bit rand_mode = 1'b0;
    bit data_eq_addr = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (data_eq_addr) return a;
        return {a[15:0], a[31:16]} ^ 32'h9E3779B9;
    endfunction

    function automatic int count_pc(input int from, input logic [31:0] p);
        int n = 0;
        for (int i = from; i < dlv.size(); i++)
            if (dlv[i] == p) n++;
        return n;
    endfunction

    task automatic model_update(input logic rst, input logic frz, input logic rq,
                                input logic [31:0] alt, input logic ack, input logic [31:0] d);
        logic        req, acc, rise, present, take, disc;
        logic [31:0] tgt, npc, nrpc;
        logic        nsq, nrpend;
        word_t       e;
        if (rst) begin
            m_pc = RESET_PC; hold.delete(); m_sq = 0; m_rpend = 0; m_rpc = 0;
            m_reqq = 0; m_instr = 0; m_ipc = 0; m_fv = 0;
        end else begin
            req     = (hold.size() == 0);
            acc     = req && ack;
            rise    = rq && !m_reqq;
            tgt     = {alt[31:2], 2'b00};
            present = m_fv || (hold.size() != 0);
            take    = acc && !m_sq;
            disc    = 0;
            npc = m_pc; nrpc = m_rpc; nsq = m_sq; nrpend = m_rpend;
            if (acc && m_sq) begin npc = m_rpc; nsq = 0; end
            if (take) begin
                if (m_rpend) begin npc = m_rpc; nrpend = 0; end
                else npc = m_pc + 32'd4;
            end
            if (rise) begin
                if (!present && take) npc = tgt;
                else if (!present) begin nrpend = 1; nrpc = tgt; end
                else if (!req || acc) begin npc = tgt; disc = acc; nsq = 0; end
                else begin nsq = 1; nrpc = tgt; end
            end
            if (!frz) begin
                if (hold.size() != 0) begin
                    e = hold.pop_front();
                    m_instr = e.data; m_ipc = e.pc; m_fv = 1; dlv.push_back(e.pc);
                end else if (take && !disc) begin
                    m_instr = d; m_ipc = {m_pc[31:2], 2'b00}; m_fv = 1; dlv.push_back(m_ipc);
                end else begin
                    m_instr = 0; m_fv = 0;
                end
            end else if (take && !disc) begin
                hold.push_back('{pc: {m_pc[31:2], 2'b00}, data: d});
            end
            m_pc = npc; m_rpc = nrpc; m_sq = nsq; m_rpend = nrpend; m_reqq = rq;
        end
    endtask

    task automatic step(input logic rst, input logic frz, input logic rq,
                        input logic [31:0] alt, input logic force_ack);
        logic        req, ack;
        logic [31:0] d;
        req = !rst && (hold.size() == 0);
        ack = (req && (wcnt >= lat)) || force_ack;
        d   = mem_word({m_pc[31:2], 2'b00});
        RESET = rst; WANT_FREEZE = frz; Request_Alt_PC = rq; Alt_PC = alt;
        IMEM_Ack = ack; IMEM_Data = d;
        #1;
        chk("imem_req", {31'b0, IMEM_Req}, {31'b0, req});
        if (req) chk("imem_addr", IMEM_Addr, {m_pc[31:2], 2'b00});
        model_update(rst, frz, rq, alt, ack, d);
        @(posedge CLK);
        #1;
        chk("instr1", Instr1_OUT, m_instr);
        chk("instr_pc", Instr_PC_OUT, m_ipc);
        chk("instr_pc_plus4", Instr_PC_Plus4_OUT, m_ipc + 32'd4);
        chk("fetch_valid", {31'b0, Fetch_Valid_OUT}, {31'b0, m_fv});
        if (req && ack) begin
            wcnt = 0;
            if (rand_mode) lat = $urandom_range(0, 3);
        end else if (req) wcnt++;
        else wcnt = 0;
    endtask

    task automatic go_to(input logic [31:0] a);
        bit hit = 0;
        step(0, 0, 1, a, 0);
        for (int i = 0; i < 40 && !hit; i++) begin
            step(0, 0, 0, a, 0);
            hit = m_fv && (m_ipc == a);
        end
        chk("goto_reached", {31'b0, hit}, 32'd1);
    endtask

    initial begin
        int mark, nval, rq_cnt, cool;
        logic rq_lvl, frz, rst;
        logic [31:0] alt_v;

        // Reset, with an ack forced during reset that must be ignored
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("rst_instr1", Instr1_OUT, 32'h0);
        chk("rst_pc", Instr_PC_OUT, 32'h0);
        chk("rst_plus4", Instr_PC_Plus4_OUT, 32'h4);
        chk("rst_valid", {31'b0, Fetch_Valid_OUT}, 32'h0);
        chk("rst_req", {31'b0, IMEM_Req}, 32'h0);

        // Zero-latency streaming, data equals address
        step(0, 0, 0, 0, 0);
        chk("s0_instr", Instr1_OUT, 32'hBFC00000);
        chk("s0_valid", {31'b0, Fetch_Valid_OUT}, 32'h1);
        chk("s0_addr", IMEM_Addr, 32'hBFC00004);
        step(0, 0, 0, 0, 0);
        chk("s1_instr", Instr1_OUT, 32'hBFC00004);
        chk("s1_plus4", Instr_PC_Plus4_OUT, 32'hBFC00008);
        chk("s1_addr", IMEM_Addr, 32'hBFC00008);

        // Three-cycle ack latency: two bubbles per instruction
        lat = 2; nval = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            if (i < 2) chk("lat_addr_stable", IMEM_Addr, 32'hBFC00008);
            nval += Fetch_Valid_OUT ? 1 : 0;
        end
        chk("lat_valid_count", nval, 32'd2);
        chk("lat_last_pc", Instr_PC_OUT, 32'hBFC0000C);

        // Branch at 0x100, slot 0x104 on output when redirect rises
        lat = 0;
        go_to(32'h100);
        step(0, 0, 0, 0, 0);
        chk("br_slot_pc", Instr_PC_OUT, 32'h104);
        step(0, 0, 1, 32'h200, 0);
        chk("br_bubble", {31'b0, Fetch_Valid_OUT}, 32'h0);
        step(0, 0, 0, 32'h200, 0);
        chk("br_target_pc", Instr_PC_OUT, 32'h200);
        chk("br_target_instr", Instr1_OUT, 32'h200);

        // Same branch, slot still outstanding when redirect rises
        go_to(32'h100);
        lat = 2;
        mark = dlv.size();
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h203, 0);
        step(0, 0, 0, 0, 0);
        chk("brd_slot_pc", Instr_PC_OUT, 32'h104);
        lat = 0;
        step(0, 0, 0, 0, 0);
        chk("brd_target_pc", Instr_PC_OUT, 32'h200);
        chk("brd_no_108", count_pc(mark, 32'h108), 32'd0);

        // Freeze for 4 cycles with an ack landing in the buffer
        go_to(32'h300);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0);
            chk("frz_hold_pc", Instr_PC_OUT, 32'h300);
            chk("frz_req_low", {31'b0, IMEM_Req}, 32'h0);
        end
        step(0, 0, 0, 0, 0);
        chk("frz_buf_pc", Instr_PC_OUT, 32'h304);
        chk("frz_reissue", IMEM_Addr, 32'h308);

        // Request held high 3 cycles while frozen: one redirect only
        go_to(32'h400);
        step(0, 0, 0, 0, 0);
        mark = dlv.size();
        step(0, 1, 1, 32'h500, 0);
        step(0, 1, 1, 32'h600, 0);
        step(0, 1, 1, 32'h600, 0);
        step(0, 1, 0, 32'h600, 0);
        step(0, 0, 0, 0, 0);
        chk("hold_first_pc", Instr_PC_OUT, 32'h500);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        chk("hold_once_500", count_pc(mark, 32'h500), 32'd1);
        chk("hold_no_600", count_pc(mark, 32'h600), 32'd0);
        chk("hold_no_408", count_pc(mark, 32'h408), 32'd0);

        // PC wrap
        go_to(32'hFFFFFFFC);
        chk("wrap_addr", IMEM_Addr, 32'h0);
        chk("wrap_plus4", Instr_PC_Plus4_OUT, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc", Instr_PC_OUT, 32'h0);

        // Reset while a request is outstanding
        lat = 3;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("rr_valid", {31'b0, Fetch_Valid_OUT}, 32'h0);
        lat = 0;
        step(0, 0, 0, 0, 0);
        chk("rr_pc", Instr_PC_OUT, 32'hBFC00000);

        // Randomized traffic against the model
        rand_mode = 1; data_eq_addr = 0; lat = $urandom_range(0, 3);
        rq_lvl = 0; rq_cnt = 0; cool = 0; alt_v = 0;
        for (int i = 0; i < 1500; i++) begin
            frz = ($urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 399) == 0);
            if (rq_cnt > 0) rq_cnt--;
            else if (cool == 0 && $urandom_range(0, 7) == 0) begin
                rq_cnt = $urandom_range(1, 3);
                cool = 12;
                alt_v = $urandom;
            end
            rq_lvl = (rq_cnt > 0);
            if (cool > 0) cool--;
            step(rst, frz, rq_lvl, alt_v, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
